cordic_seq_ctrl: RTL
====================

// Module: cordic_seq_ctrl
// PURPOSE
//  Parametrised CORDIC sequencer: the generalised controller for the shared
//  iterative CORDIC datapath. Owns the micro-rotation counter and the atan-LUT
//  address. Drives the init/iterate mux select and the two-phase register
//  enables. Adds coordinate modes (circular/linear/hyperbolic with index
//  repeats), an optional LUT wait state, back-to-back starts and abort.
// PARAMETERS
//  N_ITER    16  max LUT index + 1; indices 0..N_ITER-1; legal 2..64
//  LUT_WAIT  1   1: insert ADDR cycle before ITER1 (registered LUT); 0: none
//  CNT_W     $clog2(N_ITER)  width of iter_o (derived, do not override)
// PORTS
//  clk_i        in   1      clock, rising edge
//  rst_ni       in   1      reset, asynchronous, active-low
//  start_i      in   1      request; accepted when start_i & ready_o
//  coord_i      in   2      00 circular, 01 linear, 10 hyperbolic, 11 -> circular
//  abort_i      in   1      cancel current operation
//  ready_o      out  1      can accept start this cycle
//  busy_o       out  1      state != IDLE
//  sel_o        out  1      0: datapath loads init operands; 1: loads iterate result
//  ena1_o       out  1      stage-1 register enable
//  ena2_o       out  1      stage-2 register enable
//  iter_o       out  CNT_W  current micro-rotation index (shift amount / LUT address)
//  coord_o      out  2      coordinate mode latched at accept
//  done_tick_o  out  1      one-cycle pulse in final ITER2
// BEHAVIOUR
//  - Reset: state IDLE, iter_o=0, coord_o=00, rep flag=0, all enables/done=0,
//    sel_o=0, ready_o=1, busy_o=0.
//  - States: IDLE, INIT1, INIT2, ADDR, ITER1, ITER2.
//  - IDLE: sel=0. Accept -> INIT1. Latch coord_o (11 stored as 00).
//    Load iter_o = 1 if hyperbolic, else 0. Clear rep flag.
//  - INIT1: sel=0, ena1=1 -> INIT2.
//  - INIT2: sel=0, ena2=1 -> ADDR if LUT_WAIT, else ITER1.
//  - ADDR: sel=1, no enables -> ITER1. ITER1: sel=1, ena1=1 -> ITER2.
//  - ITER2: sel=1, ena2=1. If not final: update index, then -> ADDR/ITER1.
//  - Index update (hyperbolic only): if iter_o in {4,13,40} and rep=0, set
//    rep=1 and hold iter_o. Otherwise rep=0 and iter_o+1.
//  - Index update (other modes): iter_o+1.
//  - Final = (iter_o==N_ITER-1) & ~(hyperbolic & iter_o in {4,13,40} & rep==0).
//  - Final ITER2: done_tick_o=1. Then -> INIT1 if start accepted same cycle
//    (back-to-back, no IDLE bubble), else -> IDLE.
//  - ready_o = (IDLE | final ITER2) & ~abort_i. ready_o is combinational.
//  - iter_o is stable from ADDR/ITER1 through ITER2 of each micro-rotation.
//  - Micro-rotation count M: N_ITER for circular/linear. For hyperbolic:
//    N_ITER-1 plus one per repeat index < N_ITER.
//  - Latency: done_tick_o in cycle 2+M*(2+LUT_WAIT) after the accept edge.
//  - Abort: abort_i=1 in any non-IDLE state -> IDLE next edge.
//    That cycle: ena1/ena2/done forced 0 and no start accepted.
//    iter_o/coord_o hold. Abort in IDLE is ignored.
//  - start_i while busy (not final ITER2) is ignored, not queued.
//  - Unreachable state encoding -> IDLE, all outputs at reset values.
//  - Reset mid-operation: immediate return to reset values, no done pulse.
// TESTING
//  - Circ, N=16, W=1: start pulse -> ena1 at c1, ena2 at c2, iter_o 0..15,
//    one done_tick at c50, ready_o back to 1 at c51.
//  - Hyperbolic, N=16: iter_o sequence 1,2,3,4,4,5..13,13,14,15 (17 rotations),
//    done_tick at c53. Repeat with W=0: done_tick at c36.
//  - Back-to-back: start held high -> second INIT1 directly after done_tick cycle,
//    exactly one done per op, coord_o updates at the second accept.
//  - Abort at c20: IDLE at c21, no done_tick, no enables at c20.
//    Abort+start in IDLE: not accepted.
//  - rst_ni low at c10 mid-op: outputs at reset values asynchronously.
//    Restart after release completes normally. coord_i=11 -> coord_o=00.

Source files
------------

// File: rtl/cordic_seq_ctrl_if.sv
// Request/response bundle between a CORDIC client and its sequencer.
// Carries the start handshake, mode, abort and datapath controls.
interface cordic_seq_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [1:0]       coord_in;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             sel;
  logic             ena1;
  logic             ena2;
  logic [CNT_W-1:0] iter;
  logic [1:0]       coord;
  logic             done_tick;

  modport master (
    output start, coord_in, abort,
    input  ready, busy, sel, ena1, ena2,
    input  iter, coord, done_tick
  );

  modport slave (
    input  start, coord_in, abort,
    output ready, busy, sel, ena1, ena2,
    output iter, coord, done_tick
  );
endinterface

// File: rtl/cordic_seq_ctrl.sv
// Sequencer for a shared two-phase iterative CORDIC datapath.
// Owns rotation index, coordinate mode and hyperbolic repeat tracking.
module cordic_seq_ctrl #(
  parameter int N_ITER   = 16,
  parameter int LUT_WAIT = 1,
  parameter int CNT_W    = $clog2(N_ITER)
) (
  input logic               clk_i,
  input logic               rst_ni,
  cordic_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT1 = 3'd1,
    INIT2 = 3'd2,
    ADDR  = 3'd3,
    ITER1 = 3'd4,
    ITER2 = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] iter_q;
  logic [1:0]       coord_q;
  logic             rep_q;

  logic hyp;
  logic rep_idx;
  logic last;
  logic fin;
  logic valid;
  logic accept;
  logic ready;
  logic busy;
  logic sel;
  logic ena1;
  logic ena2;
  logic done;

  assign hyp     = (coord_q == 2'b10);
  assign rep_idx = (32'(iter_q) == 32'd4)
                 | (32'(iter_q) == 32'd13)
                 | (32'(iter_q) == 32'd40);
  assign last    = (32'(iter_q) == 32'(N_ITER - 1));
  assign fin     = (state == ITER2) & last
                 & ~(hyp & rep_idx & ~rep_q);
  assign valid   = (state <= ITER2);
  assign accept  = bus.start & ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = INIT1;
      INIT1: state_nxt = INIT2;
      INIT2: state_nxt = (LUT_WAIT != 0) ? ADDR : ITER1;
      ADDR:  state_nxt = ITER1;
      ITER1: state_nxt = ITER2;
      ITER2: begin
        if (fin) begin
          state_nxt = accept ? INIT1 : IDLE;
        end else begin
          state_nxt = (LUT_WAIT != 0) ? ADDR : ITER1;
        end
      end
      default: state_nxt = accept ? INIT1 : IDLE;
    endcase
    // abort in IDLE is harmless: accept is already blocked
    if (bus.abort) state_nxt = IDLE;
  end

  always_comb begin
    sel   = 1'b0;
    ena1  = 1'b0;
    ena2  = 1'b0;
    done  = 1'b0;
    busy  = 1'b1;
    ready = 1'b0;
    unique case (state)
      IDLE: begin
        busy  = 1'b0;
        ready = 1'b1;
      end
      INIT1: ena1 = 1'b1;
      INIT2: ena2 = 1'b1;
      ADDR:  sel  = 1'b1;
      ITER1: begin
        sel  = 1'b1;
        ena1 = 1'b1;
      end
      ITER2: begin
        sel   = 1'b1;
        ena2  = 1'b1;
        done  = fin;
        ready = fin;
      end
      default: begin
        busy  = 1'b0;
        ready = 1'b1;
      end
    endcase
    if (bus.abort) begin
      ena1  = 1'b0;
      ena2  = 1'b0;
      done  = 1'b0;
      ready = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iter_q  <= '0;
      coord_q <= 2'b00;
      rep_q   <= 1'b0;
    end else if (accept) begin
      coord_q <= (bus.coord_in == 2'b11) ? 2'b00 : bus.coord_in;
      iter_q  <= (bus.coord_in == 2'b10) ? CNT_W'(1) : '0;
      rep_q   <= 1'b0;
    end else if (!valid) begin
      iter_q  <= '0;
      coord_q <= 2'b00;
      rep_q   <= 1'b0;
    end else if (state == ITER2 && !bus.abort && !fin) begin
      // hyperbolic convergence needs indices 4,13,40 run twice
      if (hyp & rep_idx & ~rep_q) begin
        rep_q <= 1'b1;
      end else begin
        rep_q  <= 1'b0;
        iter_q <= iter_q + 1'b1;
      end
    end
  end

  assign bus.ready     = ready;
  assign bus.busy      = busy;
  assign bus.sel       = sel;
  assign bus.ena1      = ena1;
  assign bus.ena2      = ena2;
  assign bus.done_tick = done;
  assign bus.iter      = valid ? iter_q : '0;
  assign bus.coord     = valid ? coord_q : 2'b00;

endmodule
